stage_mem: RTL and testbench
============================

STAGE_MEM -- requirements
Module: stage_mem

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 16: cycles a load/store may spend waiting before abort, used only with STAGE_MEM_TIMEOUT_EN.
REQ-002 clk  input  1  single clock; all state on rising edge.
REQ-003 rst  input  1  asynchronous, active-low reset.
REQ-004 in_valid  input  1  instruction_in/alu_result/register_b_value valid this cycle.
REQ-005 instruction_in  input  32  instruction from the execute stage.
REQ-006 alu_result  input  32  execute-stage result; memory address for loads/stores.
REQ-007 register_b_value  input  32  store data.
REQ-008 stall_out  output  1  high = upstream holds its outputs; in_valid ignored.
REQ-009 mem_req_valid / mem_req_ready  output / input  1 / 1  memory request handshake.
REQ-010 mem_req_write  output  1  1 = store, 0 = load.
REQ-011 mem_addr, mem_wdata  output  32 each  request address and store data.
REQ-012 mem_resp_valid, mem_rdata  input  1, 32  load response.
REQ-013 wb_en, wb_addr, wb_data  output  1, 5, 32  register-file write port.
REQ-014 instruction_out  output  32  last retired instruction.
REQ-015 misalign_err, timeout_err  output  1 each  single-cycle error pulses.

Function
REQ-016 Decode: opcode = instruction_in[6:0]; 7'h03 LOAD, 7'h23 STORE, 7'h00 NOP, all other values ALU; rd = instruction_in[16:12].
REQ-017 States IDLE, REQ, WAIT_RESP; stall_out = 1 in every state except IDLE.
REQ-018 IDLE, in_valid, ALU: next cycle wb_en=1 for exactly one cycle, wb_addr=rd, wb_data=alu_result, instruction_out=instruction_in; state stays IDLE (latency 1, no stall).
REQ-019 IDLE, in_valid, NOP: instruction_out updated next cycle, wb_en stays 0.
REQ-020 wb_en is never asserted when rd = 0.
REQ-021 IDLE, in_valid, LOAD/STORE with alu_result[1:0] = 0: latch address, data, instruction; next state REQ.
REQ-022 LOAD/STORE with alu_result[1:0] != 0: no request, misalign_err pulses one cycle on the next cycle, instruction_out updated, no writeback, state stays IDLE.
REQ-023 REQ: mem_req_valid = 1, mem_addr/mem_wdata/mem_req_write held stable until mem_req_ready; transfer occurs on a cycle with both high.
REQ-024 STORE transfer: next state IDLE, instruction_out updated, no writeback.
REQ-025 LOAD transfer: next state WAIT_RESP; mem_resp_valid in the same cycle as transfer is not accepted.
REQ-026 WAIT_RESP, mem_resp_valid: next cycle wb_en=1 one cycle, wb_data=mem_rdata, wb_addr=rd, instruction_out updated, state IDLE.
REQ-027 mem_resp_valid outside WAIT_RESP is ignored.
REQ-028 mem_req_valid is 0 in IDLE and WAIT_RESP; at most one outstanding request.
REQ-029 When not pulsed, wb_en, misalign_err and timeout_err are 0; wb_addr/wb_data hold their last values.

Reset
REQ-030 rst low forces immediately, independent of clk: state IDLE, stall_out, mem_req_valid, mem_req_write, wb_en, misalign_err, timeout_err = 0; mem_addr, mem_wdata, wb_addr, wb_data, instruction_out = 0.
REQ-031 Reset mid-transaction abandons it; no writeback for the aborted instruction after rst is released.
REQ-032 First instruction is accepted on the first rising edge with rst high.

Configuration
REQ-033 Macro STAGE_MEM_TIMEOUT_EN defined: a counter clears on entering REQ and increments each cycle in REQ or WAIT_RESP.
REQ-034 When the count reaches TIMEOUT_CYCLES: return to IDLE, pulse timeout_err one cycle, no writeback, instruction_out updated.
REQ-035 A transfer or response on the count-reaching cycle takes priority over timeout.
REQ-036 Macro undefined: no counter, waits indefinitely, timeout_err tied to 0.

Verification
REQ-037 ALU instr rd=5, alu_result=32'h1234 -> next cycle wb_en=1, wb_addr=5, wb_data=32'h1234, stall_out never high.
REQ-038 LOAD rd=3, addr 32'h100, ready after 2 cycles, response rdata 32'hDEADBEEF 3 cycles later -> mem_addr stable 32'h100 throughout REQ; one wb_en pulse, wb_data=32'hDEADBEEF; stall_out high REQ through WAIT_RESP.
REQ-039 STORE addr 32'h40, register_b_value 32'hCAFE, ready immediately -> one transfer mem_req_write=1, mem_wdata=32'hCAFE; wb_en stays 0.
REQ-040 LOAD addr 32'h102 -> misalign_err one-cycle pulse, mem_req_valid never high; ALU rd=0 -> wb_en stays 0.
REQ-041 rst low during WAIT_RESP, then mem_resp_valid after release -> all outputs 0 at once, no wb_en pulse.
REQ-042 STAGE_MEM_TIMEOUT_EN, TIMEOUT_CYCLES=4, mem_req_ready held 0 -> timeout_err pulses after 4 REQ cycles, state IDLE, stall_out drops.

Source files
------------

// File: rtl/stage_mem_if.sv
// stage_mem_if: request/response bus between the memory stage and data memory.
// master = memory stage (issues requests), slave = memory (answers them).
interface stage_mem_if;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic        mem_req_write;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_resp_valid;
  logic [31:0] mem_rdata;

  modport master (
    output mem_req_valid,
    input  mem_req_ready,
    output mem_req_write,
    output mem_addr,
    output mem_wdata,
    input  mem_resp_valid,
    input  mem_rdata
  );

  modport slave (
    input  mem_req_valid,
    output mem_req_ready,
    input  mem_req_write,
    input  mem_addr,
    input  mem_wdata,
    output mem_resp_valid,
    output mem_rdata
  );
endinterface

// File: rtl/stage_mem.sv
// stage_mem: pipeline memory stage. ALU/NOP results retire in one cycle;
// aligned loads/stores stall upstream while one request is outstanding.
// Misaligned accesses retire immediately with a misalign_err pulse.
// Optional wait-abort timer: compile with `define STAGE_MEM_TIMEOUT_EN.
module stage_mem #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [31:0] instruction_in,
  input  logic [31:0] alu_result,
  input  logic [31:0] register_b_value,
  output logic        stall_out,
  stage_mem_if.master mem,
  output logic        wb_en,
  output logic [4:0]  wb_addr,
  output logic [31:0] wb_data,
  output logic [31:0] instruction_out,
  output logic        misalign_err,
  output logic        timeout_err
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;

  localparam logic [6:0] OP_LOAD  = 7'h03;
  localparam logic [6:0] OP_STORE = 7'h23;
  localparam logic [6:0] OP_NOP   = 7'h00;

  logic [1:0]  state;
  logic [31:0] instr_q;
  logic [4:0]  rd_q;

  logic [6:0]  opcode;
  logic [4:0]  rd_in;
  logic        is_mem;
  logic        is_alu;
  logic        aligned;
  logic        to_hit;

  // Decode the incoming instruction fields
  always_comb begin
    opcode  = instruction_in[6:0];
    rd_in   = instruction_in[16:12];
    is_mem  = (opcode == OP_LOAD) || (opcode == OP_STORE);
    is_alu  = !is_mem && (opcode != OP_NOP);
    aligned = (alu_result[1:0] == 2'b00);
  end

  assign stall_out         = (state != S_IDLE);
  assign mem.mem_req_valid = (state == S_REQ);

  // Stage FSM, request latches and retire/writeback outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state             <= S_IDLE;
      instr_q           <= '0;
      rd_q              <= '0;
      mem.mem_req_write <= 1'b0;
      mem.mem_addr      <= '0;
      mem.mem_wdata     <= '0;
      wb_en             <= 1'b0;
      wb_addr           <= '0;
      wb_data           <= '0;
      instruction_out   <= '0;
      misalign_err      <= 1'b0;
    end else begin
      wb_en        <= 1'b0;
      misalign_err <= 1'b0;
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            if (is_mem && aligned) begin
              state             <= S_REQ;
              mem.mem_addr      <= alu_result;
              mem.mem_wdata     <= register_b_value;
              mem.mem_req_write <= (opcode == OP_STORE);
              instr_q           <= instruction_in;
              rd_q              <= rd_in;
            end else begin
              instruction_out <= instruction_in;
              misalign_err    <= is_mem;
              if (is_alu && (rd_in != 5'd0)) begin
                wb_en   <= 1'b1;
                wb_addr <= rd_in;
                wb_data <= alu_result;
              end
            end
          end
        end
        S_REQ: begin
          if (mem.mem_req_ready) begin
            if (mem.mem_req_write) begin
              state           <= S_IDLE;
              instruction_out <= instr_q;
            end else begin
              state <= S_WAIT;
            end
          end else if (to_hit) begin
            state           <= S_IDLE;
            instruction_out <= instr_q;
          end
        end
        S_WAIT: begin
          if (mem.mem_resp_valid) begin
            state           <= S_IDLE;
            instruction_out <= instr_q;
            if (rd_q != 5'd0) begin
              wb_en   <= 1'b1;
              wb_addr <= rd_q;
              wb_data <= mem.mem_rdata;
            end
          end else if (to_hit) begin
            state           <= S_IDLE;
            instruction_out <= instr_q;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef STAGE_MEM_TIMEOUT_EN
  localparam logic [31:0] TO_LAST = 32'(TIMEOUT_CYCLES - 1);

  logic [31:0] to_cnt;

  // Counter value k means this is the (k+1)th busy cycle; a transfer or
  // response on the final cycle wins because to_hit requires their absence.
  assign to_hit = (((state == S_REQ) && !mem.mem_req_ready) ||
                   ((state == S_WAIT) && !mem.mem_resp_valid)) &&
                  (to_cnt == TO_LAST);

  // Busy-cycle counter (held at zero in IDLE) and abort pulse
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      to_cnt      <= '0;
      timeout_err <= 1'b0;
    end else begin
      timeout_err <= to_hit;
      if (state == S_IDLE) begin
        to_cnt <= '0;
      end else begin
        to_cnt <= to_cnt + 32'd1;
      end
    end
  end
`else
  logic unused_timeout_cfg;

  assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
  assign to_hit             = 1'b0;
  assign timeout_err        = 1'b0;
`endif

endmodule

// File: tb/tb_stage_mem.sv
// tb_stage_mem: directed and randomized checks of stage_mem against a
// transaction-level model of what each instruction must retire.
module tb_stage_mem;
  localparam int unsigned TO = 4;
`ifdef STAGE_MEM_TIMEOUT_EN
  localparam int unsigned RDY_DLY = 1;
  localparam int unsigned RSP_DLY = 0;
`else
  localparam int unsigned RDY_DLY = 2;
  localparam int unsigned RSP_DLY = 3;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [31:0] instruction_in = '0;
  logic [31:0] alu_result = '0;
  logic [31:0] register_b_value = '0;
  logic        stall_out;
  logic        wb_en;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic [31:0] instruction_out;
  logic        misalign_err;
  logic        timeout_err;

  stage_mem_if mem ();

  stage_mem #(.TIMEOUT_CYCLES(TO)) dut (
    .clk              (clk),
    .rst              (rst),
    .in_valid         (in_valid),
    .instruction_in   (instruction_in),
    .alu_result       (alu_result),
    .register_b_value (register_b_value),
    .stall_out        (stall_out),
    .mem              (mem.master),
    .wb_en            (wb_en),
    .wb_addr          (wb_addr),
    .wb_data          (wb_data),
    .instruction_out  (instruction_out),
    .misalign_err     (misalign_err),
    .timeout_err      (timeout_err)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Model of the register-file write port: last address/data written
  logic [4:0]  m_wb_addr = '0;
  logic [31:0] m_wb_data = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one instruction from IDLE and follow it to retirement
  task automatic run_instr(input logic [6:0] op, input logic [4:0] rd, input logic [31:0] addr,
                           input logic [31:0] bval, input int unsigned d_rdy,
                           input int unsigned d_rsp, input logic [31:0] rdata, input bit glitch);
    logic [31:0] ins;
    bit is_ld, is_st, is_mem, mis, wb;
    ins        = $urandom;
    ins[6:0]   = op;
    ins[16:12] = rd;
    is_ld  = (op == 7'h03);
    is_st  = (op == 7'h23);
    is_mem = is_ld || is_st;
    mis    = is_mem && (addr[1:0] != 2'b00);

    in_valid = 1'b1; instruction_in = ins; alu_result = addr; register_b_value = bval;
    step();
    in_valid = 1'b0; instruction_in = $urandom; alu_result = $urandom; register_b_value = $urandom;

    if (!is_mem || mis) begin
      wb = !is_mem && (op != 7'h00) && (rd != 5'd0);
      if (wb) begin m_wb_addr = rd; m_wb_data = addr; end
      check("fast_wb_en", wb_en, wb);
      check("fast_misalign", misalign_err, mis);
      check("fast_instr_out", instruction_out, ins);
      check("fast_stall", stall_out, 0);
      check("fast_req_valid", mem.mem_req_valid, 0);
    end else begin
      for (int i = 0; i <= int'(d_rdy); i++) begin
        check("req_stall", stall_out, 1);
        check("req_valid", mem.mem_req_valid, 1);
        check("req_addr", mem.mem_addr, addr);
        check("req_write", mem.mem_req_write, is_st);
        if (is_st) check("req_wdata", mem.mem_wdata, bval);
        check("req_wb_en", wb_en, 0);
        if (i == int'(d_rdy)) mem.mem_req_ready = 1'b1;
        if (glitch && is_ld) begin mem.mem_resp_valid = 1'b1; mem.mem_rdata = ~rdata; end
        step();
        mem.mem_req_ready = 1'b0; mem.mem_resp_valid = 1'b0;
      end
      if (is_st) begin
        check("st_stall", stall_out, 0);
        check("st_instr_out", instruction_out, ins);
        check("st_wb_en", wb_en, 0);
        check("st_req_valid", mem.mem_req_valid, 0);
      end else begin
        for (int i = 0; i <= int'(d_rsp); i++) begin
          check("wait_stall", stall_out, 1);
          check("wait_req_valid", mem.mem_req_valid, 0);
          check("wait_wb_en", wb_en, 0);
          if (i == int'(d_rsp)) begin mem.mem_resp_valid = 1'b1; mem.mem_rdata = rdata; end
          step();
          mem.mem_resp_valid = 1'b0; mem.mem_rdata = $urandom;
        end
        wb = (rd != 5'd0);
        if (wb) begin m_wb_addr = rd; m_wb_data = rdata; end
        check("ld_wb_en", wb_en, wb);
        check("ld_instr_out", instruction_out, ins);
        check("ld_stall", stall_out, 0);
      end
    end
    check("wb_addr", wb_addr, m_wb_addr);
    check("wb_data", wb_data, m_wb_data);

    // One idle cycle: pulses must drop; a stray response must be ignored
    if (glitch) begin mem.mem_resp_valid = 1'b1; mem.mem_rdata = $urandom; end
    step();
    mem.mem_resp_valid = 1'b0;
    check("idle_wb_en", wb_en, 0);
    check("idle_misalign", misalign_err, 0);
    check("idle_timeout", timeout_err, 0);
    check("idle_stall", stall_out, 0);
    check("idle_wb_data", wb_data, m_wb_data);
  endtask

  initial begin
    logic [31:0] ins;
    logic [6:0]  op;
    logic [4:0]  rd;
    logic [31:0] addr;
    int unsigned d1, d2;

    mem.mem_req_ready  = 1'b0;
    mem.mem_resp_valid = 1'b0;
    mem.mem_rdata      = '0;

    // Asynchronous reset before any clock edge
    #1 rst = 1'b0;
    #1;
    check("rst_stall", stall_out, 0);
    check("rst_req_valid", mem.mem_req_valid, 0);
    check("rst_req_write", mem.mem_req_write, 0);
    check("rst_addr", mem.mem_addr, 0);
    check("rst_wdata", mem.mem_wdata, 0);
    check("rst_wb_en", wb_en, 0);
    check("rst_wb_addr", wb_addr, 0);
    check("rst_wb_data", wb_data, 0);
    check("rst_instr_out", instruction_out, 0);
    check("rst_misalign", misalign_err, 0);
    check("rst_timeout", timeout_err, 0);
    #1 rst = 1'b1;

    // ALU retires on the first edge after release
    run_instr(7'h33, 5'd5, 32'h1234, 32'h0, 0, 0, 32'h0, 1'b0);
    // Load with delayed ready and delayed response
    run_instr(7'h03, 5'd3, 32'h100, 32'h5555, RDY_DLY, RSP_DLY, 32'hDEADBEEF, 1'b0);
    // Store accepted immediately
    run_instr(7'h23, 5'd4, 32'h40, 32'hCAFE, 0, 0, 32'h0, 1'b0);
    // Misaligned load, ALU to x0, NOP
    run_instr(7'h03, 5'd6, 32'h102, 32'h0, 0, 0, 32'h0, 1'b0);
    run_instr(7'h13, 5'd0, 32'h7777, 32'h0, 0, 0, 32'h0, 1'b0);
    run_instr(7'h00, 5'd8, 32'h9999, 32'h0, 0, 0, 32'h0, 1'b0);
    // Load whose response arrives in the transfer cycle must not take it
    run_instr(7'h03, 5'd10, 32'h204, 32'h0, 0, 0, 32'h600DF00D, 1'b1);

    // Reset while waiting for a response abandons the load
    ins = $urandom; ins[6:0] = 7'h03; ins[16:12] = 5'd7;
    in_valid = 1'b1; instruction_in = ins; alu_result = 32'h200;
    step();
    in_valid = 1'b0;
    mem.mem_req_ready = 1'b1;
    step();
    mem.mem_req_ready = 1'b0;
    check("pre_rst_stall", stall_out, 1);
    #2 rst = 1'b0;
    #1;
    check("mid_rst_stall", stall_out, 0);
    check("mid_rst_req_valid", mem.mem_req_valid, 0);
    check("mid_rst_wb_addr", wb_addr, 0);
    check("mid_rst_wb_data", wb_data, 0);
    check("mid_rst_instr_out", instruction_out, 0);
    check("mid_rst_addr", mem.mem_addr, 0);
    m_wb_addr = '0; m_wb_data = '0;
    step();
    #2 rst = 1'b1;
    mem.mem_resp_valid = 1'b1; mem.mem_rdata = 32'hBAD0BAD0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("post_rst_wb_en", wb_en, 0);
      check("post_rst_stall", stall_out, 0);
      check("post_rst_wb_data", wb_data, 0);
    end
    mem.mem_resp_valid = 1'b0;

`ifdef STAGE_MEM_TIMEOUT_EN
    // Ready never arrives: abort after TO cycles in REQ
    ins = $urandom; ins[6:0] = 7'h03; ins[16:12] = 5'd9;
    in_valid = 1'b1; instruction_in = ins; alu_result = 32'h300;
    step();
    in_valid = 1'b0;
    for (int i = 0; i < int'(TO); i++) begin
      check("to_busy_stall", stall_out, 1);
      check("to_busy_err", timeout_err, 0);
      step();
    end
    check("to_err", timeout_err, 1);
    check("to_stall", stall_out, 0);
    check("to_req_valid", mem.mem_req_valid, 0);
    check("to_wb_en", wb_en, 0);
    check("to_instr_out", instruction_out, ins);
    step();
    check("to_err_drop", timeout_err, 0);
`endif

    // Randomized instruction mix
    for (int n = 0; n < 60; n++) begin
      case ($urandom_range(0, 3))
        0: op = 7'h03;
        1: op = 7'h23;
        2: op = 7'h00;
        default: begin
          do op = 7'($urandom_range(1, 127)); while (op == 7'h03 || op == 7'h23);
        end
      endcase
      rd   = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      addr = $urandom;
      addr[1:0] = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
`ifdef STAGE_MEM_TIMEOUT_EN
      d1 = $urandom_range(0, 2);
      d2 = $urandom_range(0, 2 - d1);
`else
      d1 = $urandom_range(0, 3);
      d2 = $urandom_range(0, 3);
`endif
      run_instr(op, rd, addr, $urandom, d1, d2, $urandom, 1'($urandom_range(0, 1)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
